muldiv_opprep: RTL and testbench
================================

# muldiv_opprep

Registered operand-preparation stage for the RISC-V M-extension unit, sitting between the decode/issue side and the iterative multiplier/divider datapath. It accepts raw operands plus funct3, and produces per-operand magnitudes, result-sign, operand status flags and a resolved fast-path result, all under a valid/ready handshake. It generalises the previous combinational operand conditioner to XLEN 32/64 and adds RV64 word ops, early-out special cases and a single-entry output buffer.

## Interface
- XLEN, 32: datapath width; legal values are 32 and 64.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of the buffered entry and any same-cycle input.
- in_valid  in  1  operand request valid.
- in_ready  out  1  stage can accept a request.
- in_A  in  XLEN  rs1 value.
- in_B  in  XLEN  rs2 value.
- in_funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- in_word  in  1  RV64 *W op; ignored (treated 0) when XLEN=32.
- out_valid  out  1  prepared entry valid.
- out_ready  in  1  datapath accepts entry.
- out_A  out  XLEN  magnitude of conditioned A (two's complement if signed and negative).
- out_B  out  XLEN  magnitude of conditioned B.
- out_neg  out  1  final result must be negated.
- out_funct3  out  3  registered funct3.
- out_word  out  1  registered word flag.
- out_bypass  out  1  result resolved here; datapath must not start.
- out_result  out  XLEN  fast-path result, valid when out_bypass.
- out_status  out  6  {Bm1, B1, B0, Am1, A1, A0} of conditioned operands.

## Operation
- A signed for funct3 000/001/010/100/110; B signed for 000/001/100/110.
- Conditioning: word op takes low 32 bits, sign-extends if signed else zero-extends to XLEN; otherwise operand used as-is.
- Magnitude: signed and MSB set -> (~x + 1); else x. Most-negative value maps to itself (MSB set), unsigned interpretation is correct downstream.
- out_neg: MUL class = sA ^ sB (s = signed & MSB); DIV = sA ^ sB, forced 0 when B==0; REM = sA.
- Status: X0 = (x==0); X1 = (x==1); Xm1 = (x all ones) and operand signed; evaluated on conditioned operands.
- Fast path, priority top-down:
  - DIV/DIVU, B==0: result all ones.
  - REM/REMU, B==0: result = conditioned A.
  - DIV, A==most-negative, B==-1: result = conditioned A (overflow).
  - REM, A==most-negative, B==-1: result = 0.
  - Any MUL class with A0 or B0: result = 0.
- Word-op fast results sign-extended from bit 31. Non-bypass entries: out_result = 0.
- Single-entry output register; all out_* fields load together on accept.

## Timing
- Reset: out_valid=0, all out_* data fields 0, in_ready=1.
- in_ready = !out_valid | out_ready, forced 0 while flush=1.
- Accept when in_valid & in_ready; entry visible on out_valid the next cycle (latency 1).
- out_valid falls after out_ready handshake unless a new entry loads the same cycle; back-to-back at 1/cycle with out_ready held high.
- Data fields hold steady while out_valid & !out_ready.
- flush: out_valid cleared next edge; same-cycle input dropped; flush wins over accept.
- Reset asserted mid-operation: entry discarded immediately, no handshake completes.

## Configuration
- MULDIV_BYPASS_EN defined: fast path as above.
- Undefined: out_bypass tied 0, out_result tied 0, special-case logic absent; status flags and out_neg unchanged (datapath handles cases).

## Structure
- muldiv_pkg: funct3 localparams (MUL..REMU), status bit indices, signedness-decode function.
- One sub-module: muldiv_opcond (combinational per-operand extend/magnitude/status), instantiated twice.

## Test plan
- XLEN=32, DIV A=0xFFFFFFF9 (-7), B=2 -> out_A=7, out_B=2, out_neg=1, bypass=0, status=0.
- XLEN=32, DIV A=0x80000000, B=0xFFFFFFFF -> bypass=1, result=0x80000000, status Bm1=1; REM same operands -> result=0.
- XLEN=64, DIVUW A=0x1_0000_0005, B=0 -> bypass=1, result=0xFFFFFFFF_FFFFFFFF; REMUW -> result=5.
- MULHU A=0xFFFFFFFF, B=3 -> out_A=0xFFFFFFFF, out_neg=0, Am1=0; MUL A=0, B=9 -> bypass, result 0.
- out_ready low 3 cycles with in_valid high: in_ready low, out fields stable, second op accepted on release cycle.
- flush with out_valid=1 and in_valid=1 -> out_valid=0 next cycle, input not captured; rst_n pulse mid-hold clears out_valid asynchronously.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the M-extension operand-preparation stage:
// funct3 encodings, status-flag bit positions, operand-class and
// signedness decode.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // Bit positions inside out_status = {Bm1, B1, B0, Am1, A1, A0}
  localparam int unsigned ST_A0  = 0;
  localparam int unsigned ST_A1  = 1;
  localparam int unsigned ST_AM1 = 2;
  localparam int unsigned ST_B0  = 3;
  localparam int unsigned ST_B1  = 4;
  localparam int unsigned ST_BM1 = 5;

  typedef enum logic [1:0] {
    OPC_MUL,
    OPC_DIV,
    OPC_REM
  } op_class_e;

  function automatic op_class_e op_class(input logic [2:0] f3);
    if (!f3[2])     return OPC_MUL;
    else if (!f3[1]) return OPC_DIV;
    else            return OPC_REM;
  endfunction

  function automatic logic a_is_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
           (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic b_is_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) ||
           (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_opcond.sv
// Per-operand conditioner: word-op extension, signed magnitude and
// zero / one / minus-one detection. Purely combinational.
module muldiv_opcond
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] i_x,
  input  logic            i_signed,
  input  logic            i_word,
  output logic [XLEN-1:0] o_cond,
  output logic [XLEN-1:0] o_mag,
  output logic            o_sgn,
  output logic            o_is0,
  output logic            o_is1,
  output logic            o_ism1
);

  logic [XLEN-1:0] w_cond;

  // Word ops keep the low 32 bits and extend them per operand signedness
  always_comb begin
    w_cond = i_x;
    if (i_word) begin
      for (int unsigned i = 32; i < XLEN; i++) begin
        w_cond[i] = i_signed & i_x[31];
      end
    end
  end

  // Magnitude and flags on the conditioned operand
  always_comb begin
    o_cond = w_cond;
    o_sgn  = i_signed & w_cond[XLEN-1];
    o_mag  = o_sgn ? (~w_cond + 1'b1) : w_cond;
    o_is0  = (w_cond == '0);
    o_is1  = (w_cond == XLEN'(1));
    o_ism1 = i_signed & (&w_cond);
  end

endmodule

// File: rtl/muldiv_opprep.sv
// Registered operand-preparation stage for the M-extension unit.
// Optional early-out results are enabled with MULDIV_BYPASS_EN.
module muldiv_opprep
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_A,
  input  logic [XLEN-1:0] in_B,
  input  logic [2:0]      in_funct3,
  input  logic            in_word,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_A,
  output logic [XLEN-1:0] out_B,
  output logic            out_neg,
  output logic [2:0]      out_funct3,
  output logic            out_word,
  output logic            out_bypass,
  output logic [XLEN-1:0] out_result,
  output logic [5:0]      out_status
);

  logic            w_word, w_sa, w_sb, w_accept, w_neg, w_bypass;
  op_class_e       w_cls;
  logic [XLEN-1:0] w_cond_a, w_cond_b, w_mag_a, w_mag_b, w_result;
  logic            w_sgn_a, w_sgn_b, w_a0, w_a1, w_am1, w_b0, w_b1, w_bm1;
  logic [5:0]      w_status;

  logic            r_valid, r_neg, r_word, r_bypass;
  logic [XLEN-1:0] r_A, r_B, r_result;
  logic [2:0]      r_funct3;
  logic [5:0]      r_status;

  assign w_word = (XLEN > 32) ? in_word : 1'b0;
  assign w_sa   = a_is_signed(in_funct3);
  assign w_sb   = b_is_signed(in_funct3);
  assign w_cls  = op_class(in_funct3);

  muldiv_opcond #(.XLEN(XLEN)) u_cond_a (
    .i_x(in_A), .i_signed(w_sa), .i_word(w_word),
    .o_cond(w_cond_a), .o_mag(w_mag_a), .o_sgn(w_sgn_a),
    .o_is0(w_a0), .o_is1(w_a1), .o_ism1(w_am1)
  );

  muldiv_opcond #(.XLEN(XLEN)) u_cond_b (
    .i_x(in_B), .i_signed(w_sb), .i_word(w_word),
    .o_cond(w_cond_b), .o_mag(w_mag_b), .o_sgn(w_sgn_b),
    .o_is0(w_b0), .o_is1(w_b1), .o_ism1(w_bm1)
  );

  // Result sign and packed operand status
  always_comb begin
    w_neg = w_sgn_a;
    unique case (w_cls)
      OPC_MUL: w_neg = w_sgn_a ^ w_sgn_b;
      OPC_DIV: w_neg = (w_sgn_a ^ w_sgn_b) & ~w_b0;
      default: w_neg = w_sgn_a;
    endcase
    w_status         = '0;
    w_status[ST_A0]  = w_a0;
    w_status[ST_A1]  = w_a1;
    w_status[ST_AM1] = w_am1;
    w_status[ST_B0]  = w_b0;
    w_status[ST_B1]  = w_b1;
    w_status[ST_BM1] = w_bm1;
  end

`ifdef MULDIV_BYPASS_EN
  // Most-negative for word ops is the sign-extended 32-bit minimum
  localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W = {{(XLEN-31){1'b1}}, {31{1'b0}}};

  logic            w_min_a;
  logic [XLEN-1:0] w_fast;

  assign w_min_a = (w_cond_a == (w_word ? MIN_W : MIN_X));

  // Early-out special cases, highest priority first
  always_comb begin
    w_bypass = 1'b0;
    w_fast   = '0;
    if (w_cls == OPC_DIV && w_b0) begin
      w_bypass = 1'b1;
      w_fast   = '1;
    end else if (w_cls == OPC_REM && w_b0) begin
      w_bypass = 1'b1;
      w_fast   = w_cond_a;
    end else if (in_funct3 == F3_DIV && w_min_a && w_bm1) begin
      w_bypass = 1'b1;
      w_fast   = w_cond_a;
    end else if (in_funct3 == F3_REM && w_min_a && w_bm1) begin
      w_bypass = 1'b1;
      w_fast   = '0;
    end else if (w_cls == OPC_MUL && (w_a0 || w_b0)) begin
      w_bypass = 1'b1;
      w_fast   = '0;
    end
  end

  // Word-op fast results are sign-extended from bit 31
  always_comb begin
    w_result = w_fast;
    if (w_word) begin
      for (int unsigned i = 32; i < XLEN; i++) begin
        w_result[i] = w_fast[31];
      end
    end
  end
`else
  logic w_unused_cond;
  assign w_unused_cond = ^{w_cond_a, w_cond_b};
  assign w_bypass      = 1'b0;
  assign w_result      = '0;
`endif

  assign in_ready = (!r_valid || out_ready) && !flush;
  assign w_accept = in_valid && in_ready;

  // Single-entry output buffer; flush beats accept, data loads only on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_A      <= '0;
      r_B      <= '0;
      r_neg    <= 1'b0;
      r_funct3 <= '0;
      r_word   <= 1'b0;
      r_bypass <= 1'b0;
      r_result <= '0;
      r_status <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid  <= 1'b1;
      r_A      <= w_mag_a;
      r_B      <= w_mag_b;
      r_neg    <= w_neg;
      r_funct3 <= in_funct3;
      r_word   <= w_word;
      r_bypass <= w_bypass;
      r_result <= w_result;
      r_status <= w_status;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid  = r_valid;
  assign out_A      = r_A;
  assign out_B      = r_B;
  assign out_neg    = r_neg;
  assign out_funct3 = r_funct3;
  assign out_word   = r_word;
  assign out_bypass = r_bypass;
  assign out_result = r_result;
  assign out_status = r_status;

endmodule

// File: tb/tb_muldiv_opprep.sv
// Scoreboard bench for muldiv_opprep at XLEN=32 and XLEN=64.
// Bypass expectations follow MULDIV_BYPASS_EN.
module tb_muldiv_opprep;

  typedef struct {
    logic [63:0] a, b, res;
    logic        neg, word, bp;
    logic [2:0]  f3;
    logic [5:0]  st;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        fl32, iv32, ir32, wi32, ov32, or32, neg32, wo32, bp32;
  logic [2:0]  fi32, fo32;
  logic [31:0] a32, b32, oa32, ob32, res32;
  logic [5:0]  st32;

  logic        fl64, iv64, ir64, wi64, ov64, or64, neg64, wo64, bp64;
  logic [2:0]  fi64, fo64;
  logic [63:0] a64, b64, oa64, ob64, res64;
  logic [5:0]  st64;

  int checks = 0;
  int errors = 0;
  exp_t q32[$];
  exp_t q64[$];

  muldiv_opprep #(.XLEN(32)) u32 (
    .clk(clk), .rst_n(rst_n), .flush(fl32), .in_valid(iv32), .in_ready(ir32),
    .in_A(a32), .in_B(b32), .in_funct3(fi32), .in_word(wi32),
    .out_valid(ov32), .out_ready(or32), .out_A(oa32), .out_B(ob32),
    .out_neg(neg32), .out_funct3(fo32), .out_word(wo32), .out_bypass(bp32),
    .out_result(res32), .out_status(st32)
  );

  muldiv_opprep #(.XLEN(64)) u64 (
    .clk(clk), .rst_n(rst_n), .flush(fl64), .in_valid(iv64), .in_ready(ir64),
    .in_A(a64), .in_B(b64), .in_funct3(fi64), .in_word(wi64),
    .out_valid(ov64), .out_ready(or64), .out_A(oa64), .out_B(ob64),
    .out_neg(neg64), .out_funct3(fo64), .out_word(wo64), .out_bypass(bp64),
    .out_result(res64), .out_status(st64)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] a, input logic [63:0] b, input logic neg,
                              input logic [2:0] f3, input logic word, input logic bp,
                              input logic [63:0] res, input logic [5:0] st);
    exp_t e;
    e.a = a; e.b = b; e.neg = neg; e.f3 = f3; e.word = word; e.st = st;
`ifdef MULDIV_BYPASS_EN
    e.bp = bp; e.res = res;
`else
    e.bp = 1'b0; e.res = 64'd0;
    if (bp === 1'bx || res === 'x) e.bp = 1'b0;
`endif
    return e;
  endfunction

  task automatic cmp_out(input string tag, input exp_t e, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] res, input logic neg,
                         input logic word, input logic bp, input logic [2:0] f3,
                         input logic [5:0] st);
    chk({tag, "_A"}, a, e.a);
    chk({tag, "_B"}, b, e.b);
    chk({tag, "_neg"}, 64'(neg), 64'(e.neg));
    chk({tag, "_funct3"}, 64'(f3), 64'(e.f3));
    chk({tag, "_word"}, 64'(word), 64'(e.word));
    chk({tag, "_bypass"}, 64'(bp), 64'(e.bp));
    chk({tag, "_result"}, res, e.res);
    chk({tag, "_status"}, 64'(st), 64'(e.st));
  endtask

  // Monitors: compare every presented entry to the queue head, pop on handshake
  always @(negedge clk) begin
    if (rst_n && ov32) begin
      if (q32.size() == 0) begin
        checks++; errors++;
        $display("FAIL d32_unexpected_out actual=valid expected=idle");
      end else begin
        cmp_out("d32", q32[0], {32'd0, oa32}, {32'd0, ob32}, {32'd0, res32},
                neg32, wo32, bp32, fo32, st32);
        if (or32) void'(q32.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov64) begin
      if (q64.size() == 0) begin
        checks++; errors++;
        $display("FAIL d64_unexpected_out actual=valid expected=idle");
      end else begin
        cmp_out("d64", q64[0], oa64, ob64, res64, neg64, wo64, bp64, fo64, st64);
        if (or64) void'(q64.pop_front());
      end
    end
  end

  task automatic send(input bit sel64, input logic [2:0] f3, input logic word,
                      input logic [63:0] a, input logic [63:0] b, input exp_t e);
    bit done = 0;
    if (sel64) begin
      a64 = a; b64 = b; fi64 = f3; wi64 = word; iv64 = 1'b1;
    end else begin
      a32 = a[31:0]; b32 = b[31:0]; fi32 = f3; wi32 = word; iv32 = 1'b1;
    end
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (sel64 ? ir64 : ir32) begin
        if (sel64) q64.push_back(e); else q32.push_back(e);
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=not_accepted expected=accepted");
    end
    if (sel64) iv64 = 1'b0; else iv32 = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && (q32.size() != 0 || q64.size() != 0); i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    fl32 = 0; iv32 = 0; wi32 = 0; or32 = 1; fi32 = '0; a32 = '0; b32 = '0;
    fl64 = 0; iv64 = 0; wi64 = 0; or64 = 1; fi64 = '0; a64 = '0; b64 = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid32", 64'(ov32), 64'd0);
    chk("rst_in_ready32", 64'(ir32), 64'd1);
    chk("rst_data32", {oa32, ob32} | 64'(res32) | 64'({neg32, wo32, bp32, fo32, st32}), 64'd0);
    chk("rst_out_valid64", 64'(ov64), 64'd0);
    chk("rst_in_ready64", 64'(ir64), 64'd1);
    chk("rst_data64", oa64 | ob64 | res64 | 64'({neg64, wo64, bp64, fo64, st64}), 64'd0);
    @(posedge clk); #1;

    // XLEN=32 vectors, back to back
    send(0, 3'b100, 0, 64'hFFFFFFF9, 64'd2, mk(64'd7, 64'd2, 1, 3'b100, 0, 0, 64'd0, 6'h00));
    send(0, 3'b100, 0, 64'h80000000, 64'hFFFFFFFF,
         mk(64'h80000000, 64'd1, 0, 3'b100, 0, 1, 64'h80000000, 6'h20));
    send(0, 3'b110, 0, 64'h80000000, 64'hFFFFFFFF,
         mk(64'h80000000, 64'd1, 1, 3'b110, 0, 1, 64'd0, 6'h20));
    send(0, 3'b011, 0, 64'hFFFFFFFF, 64'd3, mk(64'hFFFFFFFF, 64'd3, 0, 3'b011, 0, 0, 64'd0, 6'h00));
    send(0, 3'b000, 0, 64'd0, 64'd9, mk(64'd0, 64'd9, 0, 3'b000, 0, 1, 64'd0, 6'h01));
    send(0, 3'b001, 0, 64'hFFFFFFFF, 64'd1, mk(64'd1, 64'd1, 1, 3'b001, 0, 0, 64'd0, 6'h14));
    send(0, 3'b101, 0, 64'd7, 64'd0, mk(64'd7, 64'd0, 0, 3'b101, 0, 1, 64'hFFFFFFFF, 6'h08));
    send(0, 3'b110, 0, 64'hFFFFFFF9, 64'd0, mk(64'd7, 64'd0, 1, 3'b110, 0, 1, 64'hFFFFFFF9, 6'h08));
    send(0, 3'b010, 0, 64'hFFFFFFFE, 64'hFFFFFFFF,
         mk(64'd2, 64'hFFFFFFFF, 1, 3'b010, 0, 0, 64'd0, 6'h00));
    send(0, 3'b011, 0, 64'd1, 64'hFFFFFFFF, mk(64'd1, 64'hFFFFFFFF, 0, 3'b011, 0, 0, 64'd0, 6'h02));
    send(0, 3'b101, 1, 64'd5, 64'd0, mk(64'd5, 64'd0, 0, 3'b101, 0, 1, 64'hFFFFFFFF, 6'h08));

    // XLEN=64 vectors including word ops
    send(1, 3'b101, 1, 64'h1_0000_0005, 64'd0,
         mk(64'd5, 64'd0, 0, 3'b101, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 6'h08));
    send(1, 3'b111, 1, 64'h1_0000_0005, 64'd0, mk(64'd5, 64'd0, 0, 3'b111, 1, 1, 64'd5, 6'h08));
    send(1, 3'b100, 1, 64'h8000_0000, 64'hFFFF_FFFF,
         mk(64'h8000_0000, 64'd1, 0, 3'b100, 1, 1, 64'hFFFF_FFFF_8000_0000, 6'h20));
    send(1, 3'b110, 1, 64'h8000_0000, 64'hFFFF_FFFF,
         mk(64'h8000_0000, 64'd1, 1, 3'b110, 1, 1, 64'd0, 6'h20));
    send(1, 3'b100, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
         mk(64'd7, 64'd2, 1, 3'b100, 0, 0, 64'd0, 6'h00));
    send(1, 3'b000, 1, 64'hFFFF_FFFF_0000_0000, 64'd5,
         mk(64'd0, 64'd5, 0, 3'b000, 1, 1, 64'd0, 6'h01));
    send(1, 3'b111, 1, 64'h8000_0000, 64'd0,
         mk(64'h8000_0000, 64'd0, 0, 3'b111, 1, 1, 64'hFFFF_FFFF_8000_0000, 6'h08));
    drain();

    // Back-pressure: hold out_ready low for 3 cycles with a second request pending
    or32 = 1'b0;
    send(0, 3'b100, 0, 64'hFFFFFFF9, 64'd2, mk(64'd7, 64'd2, 1, 3'b100, 0, 0, 64'd0, 6'h00));
    a32 = 32'd0; b32 = 32'd9; fi32 = 3'b000; wi32 = 1'b0; iv32 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(ir32), 64'd0);
      @(posedge clk); #1;
    end
    or32 = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 64'(ir32), 64'd1);
    if (ir32) q32.push_back(mk(64'd0, 64'd9, 0, 3'b000, 0, 1, 64'd0, 6'h01));
    @(posedge clk); #1;
    iv32 = 1'b0;
    drain();

    // Flush with a held entry and a same-cycle request
    or32 = 1'b0;
    send(0, 3'b011, 0, 64'hFFFFFFFF, 64'd3, mk(64'hFFFFFFFF, 64'd3, 0, 3'b011, 0, 0, 64'd0, 6'h00));
    a32 = 32'd7; b32 = 32'd0; fi32 = 3'b101; iv32 = 1'b1; fl32 = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 64'(ir32), 64'd0);
    @(posedge clk); #1;
    fl32 = 1'b0; iv32 = 1'b0;
    q32.delete();
    @(negedge clk);
    chk("flush_out_valid", 64'(ov32), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("flush_dropped_input", 64'(ov32), 64'd0);
    @(posedge clk); #1;

    // Asynchronous reset while an entry is held
    send(0, 3'b001, 0, 64'hFFFFFFFF, 64'd1, mk(64'd1, 64'd1, 1, 3'b001, 0, 0, 64'd0, 6'h14));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 64'(ov32), 64'd0);
    chk("async_rst_in_ready", 64'(ir32), 64'd1);
    q32.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_out_valid", 64'(ov32), 64'd0);
    @(posedge clk); #1;

    // Normal operation resumes
    or32 = 1'b1;
    send(0, 3'b100, 0, 64'h80000000, 64'hFFFFFFFF,
         mk(64'h80000000, 64'd1, 0, 3'b100, 0, 1, 64'h80000000, 6'h20));
    drain();
    @(posedge clk); #1;
    chk("queues_empty", 64'(q32.size() + q64.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
